// File: rtl/logic_sweep_pkg.sv
// Shared types and constants for the exhaustive 4-input logic sweep checker.
package logic_sweep_pkg;

  localparam int unsigned VEC_W   = 4;
  localparam int unsigned NUM_VEC = 16;

  // Golden F = (~y&~z) | (w&~x) | (~w&~z), bit i is F for {w,x,y,z}=i.
  localparam logic [NUM_VEC-1:0] F_GOLDEN = 16'h1F55;

  typedef enum logic [1:0] {
    IDLE,
    DRIVE,
    SAMPLE,
    DONE
  } sweep_state_t;

endpackage

// File: rtl/logic_sweep_checker_settle_timer.sv
// Settle counter: clears on request, counts while enabled, flags SETTLE-1.
module sweep_settle_timer #(
  parameter int unsigned SETTLE = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam logic [3:0] LAST = 4'(SETTLE - 1);

  logic [3:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + 4'd1;
    end
  end

  assign tc = (cnt == LAST);

endmodule

// File: rtl/logic_sweep_checker.sv
// Drives all 16 {w,x,y,z} vectors, samples dut_f after a settle time and
// scores it against a golden truth table.
module logic_sweep_checker
  import logic_sweep_pkg::*;
#(
  parameter logic [NUM_VEC-1:0] EXPECTED = F_GOLDEN,
  parameter int unsigned        SETTLE   = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       dut_f,
  output logic       w,
  output logic       x,
  output logic       y,
  output logic       z,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [4:0] fail_count,
  output logic [3:0] first_fail_idx
);

  sweep_state_t     state;
  logic [VEC_W-1:0] vec;
  logic             seen_fail;
  logic             mismatch;
  logic [4:0]       fail_sum;
  logic             timer_clr;
  logic             timer_en;
  logic             timer_tc;

  // Case inequality so an unknown DUT output is scored as a failure.
  assign mismatch  = (dut_f !== EXPECTED[vec]);
  assign fail_sum  = fail_count + 5'(mismatch);
  assign timer_clr = (((state == IDLE) || (state == DONE)) && start) || (state == SAMPLE);
  assign timer_en  = (state == DRIVE);

  sweep_settle_timer #(
    .SETTLE (SETTLE)
  ) u_settle_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (timer_clr),
    .en    (timer_en),
    .tc    (timer_tc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      vec            <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
      fail_count     <= '0;
      first_fail_idx <= '0;
      seen_fail      <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state          <= DRIVE;
            vec            <= '0;
            busy           <= 1'b1;
            done           <= 1'b0;
            pass           <= 1'b0;
            fail_count     <= '0;
            first_fail_idx <= '0;
            seen_fail      <= 1'b0;
          end
        end
        DRIVE: begin
          if (timer_tc) begin
            state <= SAMPLE;
          end
        end
        SAMPLE: begin
          fail_count <= fail_sum;
          if (mismatch && !seen_fail) begin
            first_fail_idx <= vec;
            seen_fail      <= 1'b1;
          end
          // The last vector is held after the sweep rather than wrapping.
          if (vec == VEC_W'(NUM_VEC - 1)) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= (fail_sum == 5'd0);
          end else begin
            vec   <= vec + VEC_W'(1);
            state <= DRIVE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign {w, x, y, z} = vec;

endmodule

// File: tb/tb_logic_sweep_checker.sv
// Self-checking bench: directed and randomized response tables scored
// against a truth-table model, plus NAND-only/NOR-only DUTs at SETTLE=1.
module tb_logic_sweep_checker;
  import logic_sweep_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start_a = 1'b0;
  logic        start_b = 1'b0;
  logic        dut_f_a, dut_f_b;
  logic        w_a, x_a, y_a, z_a, busy_a, done_a, pass_a;
  logic [4:0]  fc_a;
  logic [3:0]  ff_a;
  logic        w_b, x_b, y_b, z_b, busy_b, done_b, pass_b;
  logic [4:0]  fc_b;
  logic [3:0]  ff_b;
  logic [3:0]  vec_a, vec_b;
  logic [15:0] resp_tbl = F_GOLDEN;
  logic        use_nor = 1'b0;

  int unsigned checks = 0;
  int unsigned errors = 0;

  always #5 clk = ~clk;

  function automatic logic nand2(input logic a, input logic b);
    return ~(a & b);
  endfunction
  function automatic logic nand3(input logic a, input logic b, input logic c);
    return ~(a & b & c);
  endfunction
  function automatic logic nor2(input logic a, input logic b);
    return ~(a | b);
  endfunction
  function automatic logic nor3(input logic a, input logic b, input logic c);
    return ~(a | b | c);
  endfunction

  // Two-level NAND-NAND form of the sum of products.
  function automatic logic nand_impl(input logic iw, input logic ix, input logic iy, input logic iz);
    logic nw, nx, ny, nz;
    nw = nand2(iw, iw); nx = nand2(ix, ix); ny = nand2(iy, iy); nz = nand2(iz, iz);
    return nand3(nand2(ny, nz), nand2(iw, nx), nand2(nw, nz));
  endfunction

  // Two-level NOR-NOR form of (w|~z)&(~w|~x|~z)&(~w|~x|~y).
  function automatic logic nor_impl(input logic iw, input logic ix, input logic iy, input logic iz);
    logic nw, nx, ny, nz;
    nw = nor2(iw, iw); nx = nor2(ix, ix); ny = nor2(iy, iy); nz = nor2(iz, iz);
    return nor3(nor2(iw, nz), nor3(nw, nx, nz), nor3(nw, nx, ny));
  endfunction

  assign vec_a   = {w_a, x_a, y_a, z_a};
  assign vec_b   = {w_b, x_b, y_b, z_b};
  assign dut_f_a = resp_tbl[vec_a];
  assign dut_f_b = use_nor ? nor_impl(w_b, x_b, y_b, z_b) : nand_impl(w_b, x_b, y_b, z_b);

  logic_sweep_checker #(
    .EXPECTED (F_GOLDEN),
    .SETTLE   (2)
  ) dut_a (
    .clk (clk), .rst_n (rst_n), .start (start_a), .dut_f (dut_f_a),
    .w (w_a), .x (x_a), .y (y_a), .z (z_a),
    .busy (busy_a), .done (done_a), .pass (pass_a),
    .fail_count (fc_a), .first_fail_idx (ff_a)
  );

  logic_sweep_checker #(
    .EXPECTED (F_GOLDEN),
    .SETTLE   (1)
  ) dut_b (
    .clk (clk), .rst_n (rst_n), .start (start_b), .dut_f (dut_f_b),
    .w (w_b), .x (x_b), .y (y_b), .z (z_b),
    .busy (busy_b), .done (done_b), .pass (pass_b),
    .fail_count (fc_b), .first_fail_idx (ff_b)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_reset_a(input string tag);
    check({tag, "/vec"},  32'(vec_a), 32'd0);
    check({tag, "/busy"}, 32'(busy_a), 32'd0);
    check({tag, "/done"}, 32'(done_a), 32'd0);
    check({tag, "/pass"}, 32'(pass_a), 32'd0);
    check({tag, "/fail_count"}, 32'(fc_a), 32'd0);
    check({tag, "/first_fail"}, 32'(ff_a), 32'd0);
  endtask

  // Sweep on instance A with response table tbl; model scores tbl vs golden.
  task automatic run_a(input string tag, input logic [15:0] tbl, input bit noisy, input bit pre_started);
    int unsigned lat;
    logic [15:0] mism;
    int unsigned n_exp;
    int unsigned first_exp;
    resp_tbl = tbl;
    mism = tbl ^ F_GOLDEN;
    n_exp = $countones(mism);
    first_exp = 0;
    for (int i = 15; i >= 0; i--) if (mism[i]) first_exp = i;
    if (!pre_started) begin
      @(negedge clk);
      start_a = 1'b1;
    end
    @(posedge clk);
    #1;
    check({tag, "/accept_busy"}, 32'(busy_a), 32'd1);
    check({tag, "/accept_done"}, 32'(done_a), 32'd0);
    lat = 0;
    while (done_a !== 1'b1 && lat < 200) begin
      start_a = noisy ? 1'($urandom_range(1, 0)) : 1'b0;
      @(posedge clk);
      #1;
      lat++;
    end
    start_a = 1'b0;
    check({tag, "/latency"}, 32'(lat), 32'd48);
    check({tag, "/busy"}, 32'(busy_a), 32'd0);
    check({tag, "/pass"}, 32'(pass_a), (n_exp == 0) ? 32'd1 : 32'd0);
    check({tag, "/fail_count"}, 32'(fc_a), 32'(n_exp));
    check({tag, "/first_fail"}, 32'(ff_a), 32'(first_exp));
    check({tag, "/hold_vec"}, 32'(vec_a), 32'd15);
  endtask

  task automatic run_b(input string tag);
    int unsigned lat;
    @(negedge clk);
    start_b = 1'b1;
    @(posedge clk);
    #1;
    start_b = 1'b0;
    lat = 0;
    while (done_b !== 1'b1 && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check({tag, "/latency"}, 32'(lat), 32'd32);
    check({tag, "/pass"}, 32'(pass_b), 32'd1);
    check({tag, "/fail_count"}, 32'(fc_b), 32'd0);
    check({tag, "/first_fail"}, 32'(ff_b), 32'd0);
  endtask

  initial begin
    int unsigned guard;
    logic [15:0] mask;

    repeat (3) @(posedge clk);
    #1;
    check_reset_a("por");
    @(negedge clk);
    rst_n = 1'b1;

    run_a("golden", F_GOLDEN, 1'b0, 1'b0);
    run_a("tie0", 16'h0000, 1'b0, 1'b0);
    run_a("tie1", 16'hFFFF, 1'b0, 1'b0);
    run_a("e13", F_GOLDEN ^ 16'h2000, 1'b0, 1'b0);
    run_a("e13_repeat", F_GOLDEN ^ 16'h2000, 1'b0, 1'b0);

    // Reset in the middle of a failing sweep, with start held across release.
    resp_tbl = 16'h0000;
    @(negedge clk);
    start_a = 1'b1;
    @(posedge clk);
    #1;
    start_a = 1'b0;
    guard = 0;
    while (vec_a != 4'd7 && guard < 100) begin
      @(posedge clk);
      #1;
      guard++;
    end
    check("midrst/reached_vec7", 32'(vec_a), 32'd7);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_a("midrst");
    start_a = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    run_a("rst_release", F_GOLDEN, 1'b1, 1'b1);

    for (int k = 0; k < 6; k++) begin
      mask = 16'($urandom);
      if (k == 0) mask = 16'h8000;
      run_a("random", F_GOLDEN ^ mask, 1'(k % 2), 1'b0);
    end

    use_nor = 1'b0;
    run_b("nand_only");
    use_nor = 1'b1;
    run_b("nor_only");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
